// File: rtl/bin_to_bcd_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd_seq
//  Purpose  : Sequential double-dabble binary-to-BCD converter. Converts a
//             BIN_W-bit binary value into DIGITS packed BCD digits, one
//             add-3/shift step per clock. Values above 10^DIGITS-1 saturate
//             to all nines and raise ovf.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    BIN_W   : binary input width (4..14)
//    DIGITS  : number of BCD output digits (1..4)
//  Ports
//    clk    in   1          system clock, rising edge
//    reset  in   1          asynchronous reset, active low
//    start  in   1          conversion request, sampled only in IDLE
//    bin    in   BIN_W      binary value, captured with an accepted start
//    busy   out  1          high in SHIFT and DONE
//    done   out  1          one-cycle pulse; bcd/ovf updated in this cycle
//    bcd    out  4*DIGITS   packed BCD result, digit 0 in [3:0], held
//    ovf    out  1          last converted value exceeded 10^DIGITS-1, held
// ============================================================================
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam int BCD_W   = 4 * DIGITS;
    localparam int SCR_W   = BCD_W + BIN_W;
    localparam int CNT_W   = $clog2(BIN_W + 1);
    localparam int MAX_VAL = pow10(DIGITS) - 1;

    localparam logic [31:0]      MAX_VAL_U = 32'(MAX_VAL);
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BIN_W);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q,    state_d;
    logic [SCR_W-1:0]    scratch_q,  scratch_d;
    logic [CNT_W-1:0]    count_q,    count_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]    bcd_q,      bcd_d;
    logic                ovf_q,      ovf_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;

    // ------------------------------------------------------------------------
    // Combinational datapath: add-3 correction on every BCD nibble of the
    // scratch register, followed by a one-bit left shift. The binary field
    // below the BCD digits passes through the correction unchanged. Each
    // nibble is corrected independently; 5..9 + 3 stays within 4 bits so no
    // carry is ever needed between nibbles.
    // ------------------------------------------------------------------------
    logic [SCR_W-1:0] w_adj;
    logic [SCR_W-1:0] w_shifted;
    logic             w_bin_over;

    assign w_adj[BIN_W-1:0] = scratch_q[BIN_W-1:0];

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        logic [3:0] w_nib;
        assign w_nib = scratch_q[BIN_W + 4*gi +: 4];
        assign w_adj[BIN_W + 4*gi +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
    end

    // The bit shifted out of the top is always zero for in-range inputs and
    // irrelevant for out-of-range ones (the result is replaced by all nines).
    assign w_shifted = w_adj << 1;

    // Range check done once at accept time; the result is applied at DONE.
    assign w_bin_over = ({{(32-BIN_W){1'b0}}, bin} > MAX_VAL_U);

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            scratch_q  <= '0;
            count_q    <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scratch_q  <= scratch_d;
            count_q    <= count_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    //
    // SHIFT runs BIN_W add-3/shift steps (count 0..BIN_W-1) and then spends
    // one more cycle with count == BIN_W publishing the finished field into
    // bcd_q, which is when DONE is entered. Publishing only on that edge
    // keeps every intermediate scratch value off the bcd output. Because
    // start is not sampled in DONE, a continuously held start is accepted
    // on the edge that ends the single IDLE cycle following DONE.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        scratch_d  = scratch_q;
        count_d    = count_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    scratch_d  = {{BCD_W{1'b0}}, bin};
                    count_d    = '0;
                    ovf_pend_d = w_bin_over;
                    state_d    = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (count_q == LAST_CNT) begin
                    bcd_d   = ovf_pend_q ? ALL_NINES : scratch_q[SCR_W-1 -: BCD_W];
                    ovf_d   = ovf_pend_q;
                    state_d = ST_DONE;
                end else begin
                    scratch_d = w_shifted;
                    count_d   = count_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flags are derived from the next state so they are registered and
        // line up exactly with the state they describe.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bin_to_bcd_seq
//  Purpose  : Directed self-checking bench for bin_to_bcd_seq at default
//             parameters (BIN_W=14, DIGITS=4). Expected values are written
//             by hand or produced by a divide/modulo decimal model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    localparam int BIN_W   = 14;
    localparam int DIGITS  = 4;
    localparam int LATENCY = BIN_W + 1;   // edges from accepting edge to done
    localparam int TMO     = 40;          // cycle bound on any wait for done

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    bin_to_bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Decimal reference: independent of the shift/add-3 algorithm.
    function automatic logic [15:0] ref_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full single conversion from IDLE, with latency, result and hold checks.
    task automatic convert(input int v, input string tag);
        int          n;
        logic [15:0] eb;
        logic [15:0] held;
        eb    = ref_bcd(v);
        bin   = 14'(v);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, ".busy_after_start"}, busy, 1);
        chk({tag, ".no_early_done"}, done, 0);
        n = 0;
        do begin
            step();
            n++;
        end while (!done && n < TMO);
        chk({tag, ".latency"}, n, LATENCY);
        chk({tag, ".bcd"}, bcd, eb);
        chk({tag, ".ovf"}, ovf, (v > 9999) ? 1 : 0);
        chk({tag, ".busy_in_done"}, busy, 1);
        held = bcd;
        step();
        chk({tag, ".done_one_cycle"}, done, 0);
        chk({tag, ".busy_idle"}, busy, 0);
        chk({tag, ".bcd_held"}, bcd, eb);
    endtask

    initial begin
        int n;
        int pulses;

        // ---------------- reset, then idle ----------------
        reset = 1'b0;
        start = 1'b0;
        bin   = '0;
        step();
        step();
        chk("rst.bcd", bcd, 16'h0000);
        chk("rst.busy", busy, 0);
        reset = 1'b1;
        pulses = 0;
        repeat (10) begin
            step();
            if (done || busy) pulses++;
        end
        chk("idle.no_activity", pulses, 0);
        chk("idle.bcd", bcd, 16'h0000);
        chk("idle.ovf", ovf, 0);

        // ---------------- basic and boundary conversions ----------------
        convert(1234,  "c1234");
        convert(0,     "c0");
        convert(9,     "c9");
        convert(10,    "c10");
        convert(9999,  "c9999");
        convert(10000, "c10000");
        convert(16383, "c16383");
        convert(4095,  "c4095");

        // ---------------- start ignored while busy ----------------
        bin   = 14'd42;
        start = 1'b1;
        step();                       // accepting edge k
        start = 1'b0;
        step();
        step();
        bin   = 14'd7;
        start = 1'b1;
        step();                       // edge k+3, machine is in SHIFT
        start = 1'b0;
        n = 3;
        do begin
            step();
            n++;
        end while (!done && n < TMO);
        chk("busy_ign.latency", n, LATENCY);
        chk("busy_ign.bcd", bcd, 16'h0042);
        chk("busy_ign.ovf", ovf, 0);
        start = 1'b1;                 // pulse during the DONE cycle
        step();
        start = 1'b0;
        chk("busy_ign.done_drop", done, 0);
        chk("busy_ign.idle", busy, 0);
        pulses = 0;
        repeat (30) begin
            step();
            if (done) pulses++;
        end
        chk("busy_ign.no_second_done", pulses, 0);
        chk("busy_ign.bcd_held", bcd, 16'h0042);

        // ---------------- reset in the middle of a conversion ----------------
        bin   = 14'd5678;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();            // now just after edge k+7
        #3;
        reset = 1'b0;                 // asserted between clock edges
        #1;
        chk("midrst.bcd_async", bcd, 16'h0000);
        chk("midrst.busy_async", busy, 0);
        chk("midrst.done_async", done, 0);
        step();
        reset = 1'b1;
        pulses = 0;
        repeat (30) begin
            step();
            if (done || busy) pulses++;
        end
        chk("midrst.no_done", pulses, 0);
        chk("midrst.bcd_still0", bcd, 16'h0000);
        convert(5678, "c5678_after_rst");

        // ---------------- continuous start, bin stepping 0..15 ----------------
        bin   = 14'd0;
        start = 1'b1;
        for (int v = 0; v < 16; v++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!done && n < TMO);
            chk($sformatf("cont%0d.done_seen", v), done, 1);
            chk($sformatf("cont%0d.bcd", v), bcd, ref_bcd(v));
            bin = 14'(v + 1);
            if (v == 15) start = 1'b0;
            step();
            chk($sformatf("cont%0d.pulse_width", v), done, 0);
        end
        start = 1'b0;

        // ---------------- random sweep against the decimal model ----------------
        for (int i = 0; i < 200; i++) begin
            convert(int'($urandom_range(16383, 0)), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
